// File: rtl/pc_sequencer_if.sv
// Fetch-side bus of the program-counter sequencer.
// The slave modport is the sequencer; the master modport is the fetch/branch
// logic that drives control inputs and consumes the fetch address.
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             FetchReady;
  logic             Redirect;
  logic [WIDTH-1:0] RedirectPC;
  logic             Trap;
  logic             Halt;
  logic             Resume;
  logic             Call;
  logic             Ret;
  logic [WIDTH-1:0] PC;
  logic             FetchValid;
  logic             Wrapped;
  logic             Halted;
  logic             RasEmpty;

  modport master (
    output FetchReady, Redirect, RedirectPC, Trap, Halt, Resume, Call, Ret,
    input  PC, FetchValid, Wrapped, Halted, RasEmpty
  );

  modport slave (
    input  FetchReady, Redirect, RedirectPC, Trap, Halt, Resume, Call, Ret,
    output PC, FetchValid, Wrapped, Halted, RasEmpty
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter for the fetch stage: sequential advance by STEP on accepted
// fetches, redirect/trap/return loads with fixed priority, wrap to RESET_VECTOR
// above PC_LIMIT, halt/resume control.
// Optional return-address stack: define PC_SEQUENCER_RAS_EN.
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter int               STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] PC_LIMIT     = WIDTH'(52),
  parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'('h80),
  parameter int               RAS_DEPTH    = 4
) (
  input logic            Clock,
  input logic            ResetN,
  pc_sequencer_if.slave  bus
);

  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(STEP_W - 1'b1);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pc_q;
  logic             fv_q;
  logic             wrapped_q;
  logic             halted_q;

  logic [WIDTH-1:0] pc_d;
  logic             wrapped_d;
  logic             run_d;
  logic [WIDTH-1:0] cand_pc;
  logic             cand_ld;
  logic             accept;
  logic             active;
  logic             ret_sel;
  logic [WIDTH-1:0] seq_pc;

  // Return-stack view shared with the PC select logic
  logic             ras_empty;
  logic [WIDTH-1:0] ras_top;
  logic             ras_ret;

  assign accept = fv_q & bus.FetchReady;
  assign active = (state_q != BOOT);
  assign seq_pc = pc_q + STEP_W;

  assign bus.PC         = pc_q;
  assign bus.FetchValid = fv_q;
  assign bus.Wrapped    = wrapped_q;
  assign bus.Halted     = halted_q;
  assign bus.RasEmpty   = ras_empty;

`ifdef PC_SEQUENCER_RAS_EN
  localparam int                 PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W:0]     RAS_FULL = (PTR_W + 1)'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] sp_q;
  logic [PTR_W:0]   cnt_q;
  logic             push;
  logic             pop;

  assign ras_empty = (cnt_q == '0);
  assign ras_top   = ras_q[sp_q - 1'b1];
  assign ras_ret   = bus.Ret;
  // Call pushes the return address on an accepted fetch; Ret wins over Call and
  // Trap leaves the stack untouched.
  assign push      = accept & bus.Call & ~bus.Ret & ~bus.Trap;
  assign pop       = ret_sel & ~ras_empty;

  // Circular stack: sp points at the next free slot, overflow overwrites oldest
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      sp_q  <= '0;
      cnt_q <= '0;
    end else if (pop) begin
      sp_q  <= sp_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end else if (push) begin
      ras_q[sp_q] <= seq_pc;
      sp_q        <= sp_q + 1'b1;
      if (cnt_q != RAS_FULL) cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_ras_in;

  assign ras_empty     = 1'b1;
  assign ras_top       = '0;
  assign ras_ret       = 1'b0;
  assign unused_ras_in = ^{bus.Call, bus.Ret};
`endif

  // Next-PC select: Trap > Redirect > Ret > Accept > hold, with wrap check
  always_comb begin
    ret_sel   = active & ras_ret & ~bus.Trap & ~bus.Redirect;
    cand_pc   = pc_q;
    cand_ld   = 1'b0;
    pc_d      = pc_q;
    wrapped_d = 1'b0;
    if (bus.Trap) begin
      pc_d = TRAP_VECTOR;
    end else if (bus.Redirect) begin
      cand_pc = bus.RedirectPC & ALIGN_MASK;
      cand_ld = 1'b1;
    end else if (ret_sel) begin
      if (ras_empty) begin
        pc_d      = RESET_VECTOR;
        wrapped_d = 1'b1;
      end else begin
        cand_pc = ras_top;
        cand_ld = 1'b1;
      end
    end else if (accept) begin
      cand_pc = seq_pc;
      cand_ld = 1'b1;
    end
    if (cand_ld) begin
      if (cand_pc > PC_LIMIT) begin
        pc_d      = RESET_VECTOR;
        wrapped_d = 1'b1;
      end else begin
        pc_d = cand_pc;
      end
    end
    // Trap always lands in RUN; otherwise Halt beats Resume
    run_d = bus.Trap ||
            ((state_q == RUN)    && !bus.Halt) ||
            ((state_q == HALTED) && !bus.Halt && bus.Resume);
  end

  // Control FSM with registered PC and status outputs
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      state_q   <= BOOT;
      pc_q      <= RESET_VECTOR;
      fv_q      <= 1'b0;
      wrapped_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN, HALTED: begin
          pc_q      <= pc_d;
          wrapped_q <= wrapped_d;
          if (run_d) begin
            state_q  <= RUN;
            fv_q     <= 1'b1;
            halted_q <= 1'b0;
          end else begin
            state_q  <= HALTED;
            fv_q     <= 1'b0;
            halted_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= RUN;
          fv_q      <= 1'b1;
          wrapped_q <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer: table of per-cycle inputs with the
// hand-computed outputs expected after the edge, plus return-stack sequences
// when built with PC_SEQUENCER_RAS_EN.
module tb_pc_sequencer;
  localparam int WIDTH = 32;

  logic Clock  = 1'b0;
  logic ResetN = 1'b0;

  pc_sequencer_if #(.WIDTH(WIDTH)) bus ();

  pc_sequencer #(
    .WIDTH(WIDTH), .STEP(4), .RESET_VECTOR(32'h0), .PC_LIMIT(32'd52),
    .TRAP_VECTOR(32'h80), .RAS_DEPTH(4)
  ) dut (
    .Clock (Clock),
    .ResetN(ResetN),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic        rstn;
    logic        fr;
    logic        redir;
    logic [31:0] rpc;
    logic        trap;
    logic        halt;
    logic        resume;
    logic        call;
    logic        ret;
    logic [31:0] pc;
    logic        fv;
    logic        wr;
    logic        h;
    logic        empty;
  } vec_t;

  vec_t tbl[$];
  int   applied     = 0;
  int   miscompares = 0;

  function automatic vec_t mk(input logic rstn, input logic fr, input logic redir,
                              input logic [31:0] rpc, input logic trap, input logic halt,
                              input logic resume, input logic call, input logic ret,
                              input logic [31:0] pc, input logic fv, input logic wr,
                              input logic h, input logic empty);
    vec_t t;
    t.rstn = rstn; t.fr = fr; t.redir = redir; t.rpc = rpc; t.trap = trap;
    t.halt = halt; t.resume = resume; t.call = call; t.ret = ret;
    t.pc = pc; t.fv = fv; t.wr = wr; t.h = h; t.empty = empty;
    return t;
  endfunction

  task automatic apply(input vec_t t, input string name);
    @(negedge Clock);
    ResetN         = t.rstn;
    bus.FetchReady = t.fr;
    bus.Redirect   = t.redir;
    bus.RedirectPC = t.rpc;
    bus.Trap       = t.trap;
    bus.Halt       = t.halt;
    bus.Resume     = t.resume;
    bus.Call       = t.call;
    bus.Ret        = t.ret;
    @(posedge Clock);
    #1;
    applied++;
    if (bus.PC !== t.pc || bus.FetchValid !== t.fv || bus.Wrapped !== t.wr ||
        bus.Halted !== t.h || bus.RasEmpty !== t.empty) begin
      miscompares++;
      $display("FAIL %s: got PC=%h FV=%b Wr=%b Halted=%b Empty=%b, required PC=%h FV=%b Wr=%b Halted=%b Empty=%b",
               name, bus.PC, bus.FetchValid, bus.Wrapped, bus.Halted, bus.RasEmpty,
               t.pc, t.fv, t.wr, t.h, t.empty);
    end
  endtask

  initial begin
    bus.FetchReady = 1'b0; bus.Redirect = 1'b0; bus.RedirectPC = '0; bus.Trap = 1'b0;
    bus.Halt = 1'b0; bus.Resume = 1'b0; bus.Call = 1'b0; bus.Ret = 1'b0;

    // Reset for three cycles, boot cycle, then sequential fetch
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 32'h0,0,0,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0,0,0, 32'h0,1,0,0,1));
    for (int p = 4; p <= 8; p += 4) tbl.push_back(mk(1,1,0,0,0,0,0,0,0, p,1,0,0,1));
    // Stall at 8
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 32'h8,1,0,0,1));
    for (int p = 12; p <= 52; p += 4) tbl.push_back(mk(1,1,0,0,0,0,0,0,0, p,1,0,0,1));
    // Sequential past PC_LIMIT wraps, one-cycle pulse
    tbl.push_back(mk(1,1,0,0,0,0,0,0,0, 32'h0,1,1,0,1));
    for (int p = 4; p <= 16; p += 4) tbl.push_back(mk(1,1,0,0,0,0,0,0,0, p,1,0,0,1));
    // Halt at 16, hold, resume, fetch 16 then 20
    tbl.push_back(mk(1,0,0,0,0,1,0,0,0, 32'd16,0,0,1,1));
    tbl.push_back(mk(1,1,0,0,0,0,0,0,0, 32'd16,0,0,1,1));
    tbl.push_back(mk(1,1,0,0,0,0,1,0,0, 32'd16,1,0,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0,0,0, 32'd20,1,0,0,1));
    // Halt and Resume together: Halt wins, from RUN and from HALTED
    tbl.push_back(mk(1,0,0,0,0,1,1,0,0, 32'd20,0,0,1,1));
    tbl.push_back(mk(1,0,0,0,0,1,1,0,0, 32'd20,0,0,1,1));
    // Redirect while halted loads PC, stays halted; Trap forces RUN
    tbl.push_back(mk(1,0,1,32'h10,0,0,0,0,0, 32'h10,0,0,1,1));
    tbl.push_back(mk(1,0,0,0,1,0,0,0,0, 32'h80,1,0,0,1));
    // Redirect alignment, Trap over Redirect, redirect beyond limit
    tbl.push_back(mk(1,1,1,32'h1E,0,0,0,0,0, 32'h1C,1,0,0,1));
    tbl.push_back(mk(1,1,1,32'h1E,1,0,0,0,0, 32'h80,1,0,0,1));
    tbl.push_back(mk(1,1,1,32'h1E,0,0,0,0,0, 32'h1C,1,0,0,1));
    tbl.push_back(mk(1,1,1,32'h40,0,0,0,0,0, 32'h0,1,1,0,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 32'h0,1,0,0,1));
    // Sequential from unchecked TRAP_VECTOR wraps
    tbl.push_back(mk(1,0,0,0,1,0,0,0,0, 32'h80,1,0,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0,0,0, 32'h0,1,1,0,1));
    // Halt with Redirect: target loaded then halted
    tbl.push_back(mk(1,1,1,32'h30,0,1,0,0,0, 32'h30,0,0,1,1));
    tbl.push_back(mk(1,0,0,0,0,0,1,0,0, 32'h30,1,0,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0,0,0, 32'h34,1,0,0,1));
    // PC_LIMIT itself is legal, one step beyond wraps
    tbl.push_back(mk(1,1,1,32'h36,0,0,0,0,0, 32'h34,1,0,0,1));
    tbl.push_back(mk(1,1,1,32'h38,0,0,0,0,0, 32'h0,1,1,0,1));
    // Reset mid-run, then boot again
    tbl.push_back(mk(0,1,0,0,0,0,0,0,0, 32'h0,0,0,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0,0,0, 32'h0,1,0,0,1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

`ifdef PC_SEQUENCER_RAS_EN
    apply(mk(0,0,0,0,0,0,0,0,0, 32'h0,0,0,0,1), "ras_reset");
    apply(mk(1,1,0,0,0,0,0,0,0, 32'h0,1,0,0,1), "ras_boot");
    apply(mk(1,1,0,0,0,0,0,0,0, 32'h4,1,0,0,1), "ras_seq4");
    apply(mk(1,1,0,0,0,0,0,0,0, 32'h8,1,0,0,1), "ras_seq8");
    apply(mk(1,1,0,0,0,0,0,1,0, 32'hC,1,0,0,0), "ras_call");
    apply(mk(1,1,1,32'd40,0,0,0,0,0, 32'd40,1,0,0,0), "ras_redir40");
    apply(mk(1,1,0,0,0,0,0,0,1, 32'hC,1,0,0,1), "ras_ret");
    apply(mk(1,1,0,0,0,0,0,0,1, 32'h0,1,1,0,1), "ras_ret_empty");
    apply(mk(1,1,0,0,0,0,0,1,1, 32'h0,1,1,0,1), "ras_call_ret");
    apply(mk(1,1,0,0,0,0,0,1,0, 32'h4,1,0,0,0), "ras_push4");
    apply(mk(1,1,0,0,0,0,0,1,0, 32'h8,1,0,0,0), "ras_push8");
    apply(mk(1,1,0,0,1,0,0,0,1, 32'h80,1,0,0,0), "ras_trap_keeps");
    apply(mk(1,0,1,32'h10,0,0,0,0,0, 32'h10,1,0,0,0), "ras_redir16");
    apply(mk(1,0,0,0,0,0,0,0,1, 32'h8,1,0,0,0), "ras_pop8");
    apply(mk(0,1,0,0,0,0,0,0,0, 32'h0,0,0,0,1), "ras_mid_reset");
    apply(mk(1,1,0,0,0,0,0,0,1, 32'h0,1,0,0,1), "ras_boot2");
    apply(mk(1,0,0,0,0,0,0,0,1, 32'h0,1,1,0,1), "ras_ret_after_reset");
`else
    // Call/Ret have no effect without the stack
    apply(mk(1,1,0,0,0,0,0,1,0, 32'h4,1,0,0,1), "noras_call");
    apply(mk(1,1,0,0,0,0,0,0,1, 32'h8,1,0,0,1), "noras_ret");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
